mul_pipe_unit: RTL and testbench

- Parametrised multicycle integer multiplier for the CPU execute stage; serves both MULT (signed) and MULTU (unsigned) and writes HI/LO.
- Operands are captured on an accepted start. Partial products are reduced through a registered binary adder tree.
- Result and a one-cycle done pulse appear after a fixed latency. Busy gates the pipeline stall logic.

---
 rtl/mul_pipe_unit.sv | 94 +++++++++
 tb/tb_mul_pipe_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_unit.sv
// Multicycle integer multiplier for MULT/MULTU. Sign-magnitude operands,
// registered partial products and a registered binary adder tree, result on HI/LO.
module mul_pipe_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   res,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int LOG2W = $clog2(WIDTH);
    localparam int CW    = $clog2(LOG2W + 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOG2W + 1);

    // state | meaning
    // IDLE  | waiting for start, res holds last product
    // RUN   | cnt 0: partial products, 1..LOG2W: tree levels, LOG2W+1: completion
    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic               state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic [2*WIDTH-1:0] tree [WIDTH];

    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    assign a_mag_in = (is_signed & a[WIDTH-1]) ? -a : a;
    assign b_mag_in = (is_signed & b[WIDTH-1]) ? -b : b;

    // The tree reduces in place: each level sums adjacent pairs into the
    // lower half and zeroes the upper half, so after LOG2W levels tree[0]
    // holds the full sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                tree[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    mag_a <= a_mag_in;
                    mag_b <= b_mag_in;
                    neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    cnt   <= '0;
                    state <= RUN;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        tree[i] <= mag_b[i] ? ({{WIDTH{1'b0}}, mag_a} << i) : '0;
                    end
                end else if (cnt == CNT_LAST) begin
                    res   <= neg ? -tree[0] : tree[0];
                    done  <= 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end else begin
                    for (int i = 0; i < WIDTH / 2; i++) begin
                        tree[i] <= tree[2*i] + tree[2*i+1];
                    end
                    for (int i = WIDTH / 2; i < WIDTH; i++) begin
                        tree[i] <= '0;
                    end
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign hi   = res[2*WIDTH-1:WIDTH];
    assign lo   = res[WIDTH-1:0];

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Directed bench for mul_pipe_unit: a 32-bit and an 8-bit instance sharing
// clock and reset, checked against hand-computed products.
module tb_mul_pipe_unit;

    logic        clk;
    logic        reset;

    logic        start32, sg32;
    logic [31:0] a32, b32;
    logic        busy32, done32;
    logic [63:0] res32;
    logic [31:0] hi32, lo32;

    logic        start8, sg8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] res8;
    logic [7:0]  hi8, lo8;

    int n_tests = 0;
    int n_fail  = 0;

    mul_pipe_unit #(.WIDTH(32)) u_mul32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sg32),
        .a(a32), .b(b32), .busy(busy32), .done(done32),
        .res(res32), .hi(hi32), .lo(lo32)
    );

    mul_pipe_unit #(.WIDTH(8)) u_mul8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .res(res8), .hi(hi8), .lo(lo8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Must be called at a negedge; returns at the negedge after the done edge.
    task automatic run_op(input bit w8, input bit sg, input logic [63:0] av, input logic [63:0] bv,
                          input logic [127:0] exp_res, input int exp_lat, input string tag);
        int lat;
        int busy_cnt;
        bit stable;
        logic [63:0] prev;
        if (w8) begin
            sg8 = sg; a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1;
        end else begin
            sg32 = sg; a32 = av[31:0]; b32 = bv[31:0]; start32 = 1'b1;
        end
        prev = w8 ? {48'd0, res8} : res32;
        @(negedge clk);
        start8 = 1'b0;
        start32 = 1'b0;
        check_val({tag, "_done_low_after_accept"}, w8 ? done8 : done32, 1'b0);
        lat = 0;
        busy_cnt = (w8 ? busy8 : busy32) ? 1 : 0;
        stable = 1'b1;
        while (!(w8 ? done8 : done32) && lat < 16) begin
            @(negedge clk);
            lat++;
            if (w8 ? busy8 : busy32) busy_cnt++;
            if (!(w8 ? done8 : done32) && ((w8 ? {48'd0, res8} : res32) != prev)) stable = 1'b0;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_busy_cycles"}, busy_cnt, exp_lat);
        check_val({tag, "_busy_low_at_done"}, w8 ? busy8 : busy32, 1'b0);
        check_val({tag, "_res_stable"}, stable, 1'b1);
        check_val({tag, "_res"}, w8 ? {48'd0, res8} : res32, exp_res);
    endtask

    initial begin
        int n_done;
        int done_lat;
        reset = 1'b1;
        start32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
        #12;
        check_val("reset_busy32", busy32, 1'b0);
        check_val("reset_done32", done32, 1'b0);
        check_val("reset_res32", res32, 64'd0);
        check_val("reset_res8", res8, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001, 7, "u32_max");
        check_val("u32_max_hi", hi32, 32'hFFFFFFFE);
        check_val("u32_max_lo", lo32, 32'h00000001);
        @(negedge clk);
        check_val("u32_max_done_one_cycle", done32, 1'b0);

        run_op(1'b0, 1'b1, 64'hFFFFFFFD, 64'd5, 128'hFFFFFFFFFFFFFFF1, 7, "s32_m3x5");
        run_op(1'b0, 1'b1, 64'h80000000, 64'h80000000, 128'h4000000000000000, 7, "s32_minxmin");
        run_op(1'b0, 1'b1, 64'hFFFFFFFF, 64'd0, 128'd0, 7, "s32_zero");
        @(negedge clk);

        // Operand isolation: inputs change mid-flight, second start while busy
        a32 = 32'd7; b32 = 32'd6; sg32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        a32 = '0; b32 = '0; sg32 = 1'b1;
        @(negedge clk);
        start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        n_done = 0;
        done_lat = 0;
        for (int k = 4; k <= 16; k++) begin
            @(negedge clk);
            if (done32) begin
                n_done++;
                if (done_lat == 0) done_lat = k;
                check_val("iso_res", res32, 64'd42);
            end
        end
        check_val("iso_done_count", n_done, 1);
        check_val("iso_latency", done_lat, 7);

        // Back-to-back: second start on the cycle after done
        run_op(1'b0, 1'b0, 64'd7, 64'd6, 128'd42, 7, "b2b_first");
        check_val("b2b_first_done", done32, 1'b1);
        run_op(1'b0, 1'b0, 64'd2, 64'd3, 128'd6, 7, "b2b_second");
        @(negedge clk);
        check_val("b2b_no_dup_done", done32, 1'b0);

        // Reset in the middle of an operation
        a32 = 32'hFFFFFFFF; b32 = 32'd2; sg32 = 1'b0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("rst_mid_busy", busy32, 1'b0);
        check_val("rst_mid_res", res32, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done32) n_done++;
        end
        check_val("rst_mid_no_done", n_done, 0);
        check_val("rst_mid_idle", busy32, 1'b0);
        run_op(1'b0, 1'b0, 64'hFFFFFFFF, 64'd2, 128'h1FFFFFFFE, 7, "rst_after");

        // 8-bit instance
        @(negedge clk);
        run_op(1'b1, 1'b0, 64'hFF, 64'hFF, 128'hFE01, 5, "u8_max");
        check_val("u8_max_hi", hi8, 8'hFE);
        check_val("u8_max_lo", lo8, 8'h01);
        run_op(1'b1, 1'b1, 64'h80, 64'h7F, 128'hC080, 5, "s8_minxmax");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
